// File: rtl/atanh_pwl.sv
`default_nettype none
// ============================================================================
// Module      : atanh_pwl
// Description : Pipelined inverse of the piecewise-linear tanh approximation.
//               Maps a signed fixed-point activation y (1.0 = SCALE) back to
//               its pre-activation x through three registered stages
//               (classify / invert / sign+saturate) under a valid/ready
//               handshake, and counts saturated results handed downstream.
// Ports       : clk        - clock, rising edge
//               rst_n      - asynchronous active-low reset
//               in_valid   - input sample valid
//               in_ready   - block can accept a sample this cycle
//               in_y       - signed activation value, scale SCALE
//               out_valid  - result valid
//               out_ready  - downstream accepts the result
//               out_x      - signed recovered pre-activation, scale SCALE
//               out_sat    - result was saturated (qualified by out_valid)
//               sat_clr    - synchronous clear of sat_count
//               sat_count  - saturated results handed off, sticks at all-ones
// Revision    : 1.0 - initial release
// ============================================================================
module atanh_pwl #(
  parameter int SCALE = 100000000,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_y,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_x,
  output logic             out_sat,
  input  logic             sat_clr,
  output logic [CNT_W-1:0] sat_count
);

  // Segment edges (upper edge inclusive) and linear-segment offsets.
  // Products are formed as (SCALE/n)*k to stay inside 32-bit int arithmetic.
  localparam logic [32:0] c_lim_a = 33'(SCALE / 2);         // 0.50
  localparam logic [32:0] c_lim_b = 33'((SCALE / 20) * 17); // 0.85
  localparam logic [32:0] c_lim_c = 33'(SCALE);             // 1.00
  localparam logic [31:0] c_off_b = 32'(SCALE / 4);         // 0.25
  localparam logic [31:0] c_off_c = 32'((SCALE / 10) * 7);  // 0.70

  localparam logic [31:0] c_pos_max = 32'h7FFF_FFFF;
  localparam logic [31:0] c_neg_max = 32'h8000_0000;

  localparam logic [1:0] c_seg_a = 2'd0;
  localparam logic [1:0] c_seg_b = 2'd1;
  localparam logic [1:0] c_seg_c = 2'd2;
  localparam logic [1:0] c_seg_s = 2'd3;

  // --------------------------------------------------------------------------
  // Handshake: a single stall term freezes every stage at once, so the
  // pipeline never needs per-stage skid storage.
  // --------------------------------------------------------------------------
  logic w_stall;
  logic r_v1;
  logic r_v2;
  logic r_v3;

  assign w_stall   = r_v3 && !out_ready;
  assign in_ready  = !w_stall;
  assign out_valid = r_v3;

  // --------------------------------------------------------------------------
  // Stage 1: sign, magnitude and segment classification.
  // The magnitude is formed in 33 bits so that -2^31 becomes +2^31 rather
  // than wrapping back to a negative number.
  // --------------------------------------------------------------------------
  logic [32:0] w_mag;
  logic [1:0]  w_seg;

  always_comb begin
    w_mag = in_y[31] ? (33'd0 - {in_y[31], in_y}) : {1'b0, in_y};
    w_seg = c_seg_s;
    if (w_mag <= c_lim_a) begin
      w_seg = c_seg_a;
    end else if (w_mag <= c_lim_b) begin
      w_seg = c_seg_b;
    end else if (w_mag <= c_lim_c) begin
      w_seg = c_seg_c;
    end
  end

  logic        r_s1_sign;
  logic [31:0] r_s1_mag;  // only meaningful for non-saturating segments
  logic [1:0]  r_s1_seg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_v1      <= 1'b0;
      r_s1_sign <= 1'b0;
      r_s1_mag  <= 32'd0;
      r_s1_seg  <= c_seg_a;
    end else if (!w_stall) begin
      r_v1 <= in_valid;
      if (in_valid) begin
        r_s1_sign <= in_y[31];
        r_s1_mag  <= w_mag[31:0];
        r_s1_seg  <= w_seg;
      end
    end
  end

  // --------------------------------------------------------------------------
  // Stage 2: invert the selected linear segment. Segment slopes of tanh are
  // 1, 1/2 and 1/8, so the inverse slopes are plain left shifts.
  // Largest result is (1.0 - 0.7) * 8 = 2.4, well inside 32-bit signed.
  // --------------------------------------------------------------------------
  logic [31:0] w_r2;
  logic        w_sat2;

  always_comb begin
    w_r2   = 32'd0;
    w_sat2 = 1'b0;
    case (r_s1_seg)
      c_seg_a: w_r2 = r_s1_mag;
      c_seg_b: w_r2 = (r_s1_mag - c_off_b) << 1;
      c_seg_c: w_r2 = (r_s1_mag - c_off_c) << 3;
      default: w_sat2 = 1'b1;
    endcase
  end

  logic        r_s2_sign;
  logic [31:0] r_s2_r;
  logic        r_s2_sat;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_v2      <= 1'b0;
      r_s2_sign <= 1'b0;
      r_s2_r    <= 32'd0;
      r_s2_sat  <= 1'b0;
    end else if (!w_stall) begin
      r_v2 <= r_v1;
      if (r_v1) begin
        r_s2_sign <= r_s1_sign;
        r_s2_r    <= w_r2;
        r_s2_sat  <= w_sat2;
      end
    end
  end

  // --------------------------------------------------------------------------
  // Stage 3: re-apply the sign, or clamp to the signed 32-bit extremes.
  // --------------------------------------------------------------------------
  logic [31:0] w_x3;

  always_comb begin
    w_x3 = r_s2_r;
    if (r_s2_sat) begin
      w_x3 = r_s2_sign ? c_neg_max : c_pos_max;
    end else if (r_s2_sign) begin
      w_x3 = 32'd0 - r_s2_r;
    end
  end

  logic [31:0] r_out_x;
  logic        r_out_sat;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_v3      <= 1'b0;
      r_out_x   <= 32'd0;
      r_out_sat <= 1'b0;
    end else if (!w_stall) begin
      r_v3 <= r_v2;
      if (r_v2) begin
        r_out_x   <= w_x3;
        r_out_sat <= r_s2_sat;
      end
    end
  end

  assign out_x   = r_out_x;
  assign out_sat = r_out_sat;

  // --------------------------------------------------------------------------
  // Saturation counter: counts only results actually handed off, sticks at
  // all-ones, and a clear wins over a coincident increment.
  // --------------------------------------------------------------------------
  logic [CNT_W-1:0] r_sat_count;
  logic             w_sat_xfer;

  assign w_sat_xfer = r_v3 && out_ready && r_out_sat;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sat_count <= '0;
    end else if (sat_clr) begin
      r_sat_count <= '0;
    end else if (w_sat_xfer && (r_sat_count != {CNT_W{1'b1}})) begin
      r_sat_count <= r_sat_count + 1'b1;
    end
  end

  assign sat_count = r_sat_count;

endmodule
`default_nettype wire

// File: tb/tb_atanh_pwl.sv
`default_nettype none
// ============================================================================
// Module      : tb_atanh_pwl
// Description : Self-checking bench for atanh_pwl. A default instance
//               (CNT_W = 16) and a narrow-counter instance (CNT_W = 4) share
//               all inputs; results are compared with a behavioural model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_atanh_pwl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic [31:0] in_y = 32'd0;
  logic        out_ready = 1'b1;
  logic        sat_clr = 1'b0;

  wire         in_ready;
  wire         out_valid;
  wire  [31:0] out_x;
  wire         out_sat;
  wire  [15:0] sat_count;

  wire         s_in_ready;
  wire         s_out_valid;
  wire  [31:0] s_out_x;
  wire         s_out_sat;
  wire  [3:0]  s_sat_count;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  atanh_pwl dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_y(in_y),
    .out_valid(out_valid), .out_ready(out_ready), .out_x(out_x), .out_sat(out_sat),
    .sat_clr(sat_clr), .sat_count(sat_count)
  );

  atanh_pwl #(.CNT_W(4)) dut_small (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(s_in_ready), .in_y(in_y),
    .out_valid(s_out_valid), .out_ready(out_ready), .out_x(s_out_x), .out_sat(s_out_sat),
    .sat_clr(sat_clr), .sat_count(s_sat_count)
  );

  // Behavioural reference: {sat, x}
  function automatic logic [32:0] model(input logic [31:0] y);
    longint v, m, r;
    v = longint'($signed(y));
    m = (v < 0) ? -v : v;
    if (m > 100000000) return {1'b1, (v < 0) ? 32'h8000_0000 : 32'h7FFF_FFFF};
    if (m <= 50000000)      r = m;
    else if (m <= 85000000) r = 2 * (m - 25000000);
    else                    r = 8 * (m - 70000000);
    if (v < 0) r = -r;
    return {1'b0, r[31:0]};
  endfunction

  function automatic logic [31:0] rand_y();
    int sel;
    int bnd [8] = '{50000000, 50000001, 85000000, 85000001,
                    100000000, 100000001, 0, 1};
    logic [31:0] y;
    sel = int'($urandom_range(0, 3));
    case (sel)
      0: y = $urandom;
      1: y = $urandom_range(0, 220000000) - 32'd110000000;
      2: begin
        y = bnd[$urandom_range(0, 7)];
        if ($urandom_range(0, 1) == 1) y = 32'd0 - y;
        if ($urandom_range(0, 7) == 0) y = 32'h8000_0000;
      end
      default: y = $urandom_range(0, 2000) - 32'd1000;
    endcase
    return y;
  endfunction

  task automatic test_reset;
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1; sat_clr = 1'b0;
    repeat (3) @(negedge clk);
    n_tests++;
    if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
    n_tests++;
    if (out_x !== 32'd0) begin n_fail++; $display("FAIL reset_out_x: got %h want 0", out_x); end
    n_tests++;
    if (out_sat !== 1'b0) begin n_fail++; $display("FAIL reset_out_sat: got %b want 0", out_sat); end
    n_tests++;
    if (sat_count !== 16'd0) begin n_fail++; $display("FAIL reset_sat_count: got %0d want 0", sat_count); end
    @(posedge clk); #2 rst_n = 1'b1;
    @(negedge clk);
    n_tests++;
    if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
  endtask

  task automatic test_directed;
    int ys [8] = '{30000000, 60000000, -90000000, 100000000,
                   50000000, 85000000, -85000001, 0};
    int xs [8] = '{30000000, 70000000, -160000000, 240000000,
                   50000000, 120000000, -120000008, 0};
    for (int i = 0; i < 8; i++) begin
      int lat;
      @(posedge clk); #1 in_valid = 1'b1; in_y = ys[i]; out_ready = 1'b1;
      @(negedge clk);
      n_tests++;
      if (in_ready !== 1'b1) begin n_fail++; $display("FAIL directed_in_ready[%0d]: got %b want 1", i, in_ready); end
      @(posedge clk); #1 in_valid = 1'b0;
      lat = 0;
      while (lat < 10) begin
        @(negedge clk); lat++;
        if (out_valid === 1'b1) break;
      end
      n_tests++;
      if (lat != 3) begin n_fail++; $display("FAIL directed_latency[%0d]: got %0d want 3", i, lat); end
      n_tests++;
      if (out_x !== xs[i]) begin n_fail++; $display("FAIL directed_x y=%0d: got %0d want %0d", ys[i], $signed(out_x), xs[i]); end
      n_tests++;
      if (out_sat !== 1'b0) begin n_fail++; $display("FAIL directed_sat y=%0d: got %b want 0", ys[i], out_sat); end
    end
  endtask

  task automatic test_saturation;
    logic [31:0] ys [2] = '{32'd100000001, 32'h8000_0000};
    logic [31:0] xs [2] = '{32'h7FFF_FFFF, 32'h8000_0000};
    int lat;
    for (int i = 0; i < 2; i++) begin
      @(posedge clk); #1 in_valid = 1'b1; in_y = ys[i]; out_ready = 1'b1;
      @(posedge clk); #1 in_valid = 1'b0;
      lat = 0;
      while (lat < 10) begin
        @(negedge clk); lat++;
        if (out_valid === 1'b1) break;
      end
      n_tests++;
      if (lat != 3) begin n_fail++; $display("FAIL sat_latency[%0d]: got %0d want 3", i, lat); end
      n_tests++;
      if (out_x !== xs[i]) begin n_fail++; $display("FAIL sat_x[%0d]: got %h want %h", i, out_x, xs[i]); end
      n_tests++;
      if (out_sat !== 1'b1) begin n_fail++; $display("FAIL sat_flag[%0d]: got %b want 1", i, out_sat); end
    end
    @(posedge clk); #1;
    n_tests++;
    if (sat_count !== 16'd2) begin n_fail++; $display("FAIL sat_count_two: got %0d want 2", sat_count); end
    sat_clr = 1'b1;
    @(posedge clk); #1 sat_clr = 1'b0;
    n_tests++;
    if (sat_count !== 16'd0) begin n_fail++; $display("FAIL sat_clr: got %0d want 0", sat_count); end
    // clear coincident with a saturated hand-off must win
    @(posedge clk); #1 in_valid = 1'b1; in_y = 32'd100000001;
    @(posedge clk); #1 in_valid = 1'b0;
    lat = 0;
    while (lat < 10) begin
      @(negedge clk); lat++;
      if (out_valid === 1'b1) break;
    end
    sat_clr = 1'b1;
    @(posedge clk); #1 sat_clr = 1'b0;
    n_tests++;
    if (sat_count !== 16'd0) begin n_fail++; $display("FAIL sat_clr_priority: got %0d want 0", sat_count); end
    @(posedge clk); #1;
    n_tests++;
    if (sat_count !== 16'd0) begin n_fail++; $display("FAIL sat_clr_after: got %0d want 0", sat_count); end
  endtask

  task automatic test_backpressure;
    logic [31:0] ys [5];
    logic [32:0] exp_q [$];
    logic [32:0] e;
    logic [31:0] held_x;
    logic        held_sat;
    logic        seen;
    int sent, got, hold, cyc;
    sent = 0; got = 0; hold = 0; cyc = 0; seen = 1'b0;
    held_x = 32'd0; held_sat = 1'b0;
    for (int i = 0; i < 5; i++) ys[i] = $urandom_range(0, 220000000) - 32'd110000000;
    while (got < 5 && cyc < 100) begin
      @(posedge clk); #1;
      if (sent < 5) begin in_valid = 1'b1; in_y = ys[sent]; end
      else in_valid = 1'b0;
      out_ready = seen && (hold >= 4);
      @(negedge clk); cyc++;
      if (in_valid && in_ready) begin exp_q.push_back(model(ys[sent])); sent++; end
      if (out_valid === 1'b1) begin
        if (!out_ready) begin
          if (!seen) begin
            seen = 1'b1; held_x = out_x; held_sat = out_sat;
            n_tests++;
            if (exp_q.size() == 0 || {out_sat, out_x} !== exp_q[0]) begin
              n_fail++; $display("FAIL bp_first: got %b/%h want %h", out_sat, out_x, (exp_q.size() > 0) ? exp_q[0] : 33'd0);
            end
          end else begin
            n_tests++;
            if (out_x !== held_x || out_sat !== held_sat) begin
              n_fail++; $display("FAIL bp_stable: got %b/%h want %b/%h", out_sat, out_x, held_sat, held_x);
            end
          end
          n_tests++;
          if (in_ready !== 1'b0) begin n_fail++; $display("FAIL bp_in_ready: got %b want 0", in_ready); end
          hold++;
        end else begin
          e = (exp_q.size() > 0) ? exp_q.pop_front() : 33'h1_DEAD_BEEF;
          n_tests++;
          if ({out_sat, out_x} !== e) begin n_fail++; $display("FAIL bp_order[%0d]: got %b/%h want %h", got, out_sat, out_x, e); end
          got++;
        end
      end
    end
    in_valid = 1'b0; out_ready = 1'b1;
    n_tests++;
    if (got != 5 || hold != 4 || exp_q.size() != 0) begin
      n_fail++; $display("FAIL bp_count: got %0d results %0d stall cycles, want 5 and 4", got, hold);
    end
  endtask

  task automatic test_random;
    logic [32:0] exp_q [$];
    logic [32:0] e;
    logic [31:0] pend;
    logic        have;
    int sent, got;
    sent = 0; got = 0; have = 1'b0; pend = 32'd0;
    for (int c = 0; c < 340; c++) begin
      @(posedge clk); #1;
      if (c < 300) begin
        if (!have && ($urandom_range(0, 3) != 0)) begin pend = rand_y(); have = 1'b1; end
        in_valid = have; in_y = pend;
        out_ready = ($urandom_range(0, 3) != 0);
      end else begin
        in_valid = 1'b0; out_ready = 1'b1;
      end
      @(negedge clk);
      if (in_valid && in_ready) begin exp_q.push_back(model(in_y)); sent++; have = 1'b0; end
      if (out_valid === 1'b1 && out_ready) begin
        e = (exp_q.size() > 0) ? exp_q.pop_front() : 33'h1_DEAD_BEEF;
        n_tests++;
        if ({out_sat, out_x} !== e) begin n_fail++; $display("FAIL random[%0d]: got %b/%h want %h", got, out_sat, out_x, e); end
        got++;
      end
    end
    in_valid = 1'b0; out_ready = 1'b1;
    n_tests++;
    if (got != sent || exp_q.size() != 0) begin
      n_fail++; $display("FAIL random_count: got %0d results want %0d", got, sent);
    end
  endtask

  task automatic test_reset_midstream;
    int lat;
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1 in_valid = 1'b1; in_y = 32'd100000001 + i;
    end
    #3 rst_n = 1'b0;
    #1;
    n_tests++;
    if (out_valid !== 1'b0) begin n_fail++; $display("FAIL mid_rst_valid: got %b want 0", out_valid); end
    n_tests++;
    if (sat_count !== 16'd0 || s_sat_count !== 4'd0) begin
      n_fail++; $display("FAIL mid_rst_count: got %0d/%0d want 0", sat_count, s_sat_count);
    end
    n_tests++;
    if (out_x !== 32'd0 || out_sat !== 1'b0) begin n_fail++; $display("FAIL mid_rst_data: got %b/%h want 0", out_sat, out_x); end
    in_valid = 1'b0;
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1 in_valid = 1'b1; in_y = 32'd60000000;
    @(posedge clk); #1 in_valid = 1'b0;
    lat = 0;
    while (lat < 10) begin
      @(negedge clk); lat++;
      if (out_valid === 1'b1) break;
    end
    n_tests++;
    if (lat != 3) begin n_fail++; $display("FAIL mid_rst_latency: got %0d want 3", lat); end
    n_tests++;
    if (out_x !== 32'd70000000) begin n_fail++; $display("FAIL mid_rst_x: got %0d want 70000000", out_x); end
  endtask

  task automatic test_counter_ceiling;
    sat_clr = 1'b1;
    @(posedge clk); #1 sat_clr = 1'b0;
    n_tests++;
    if (sat_count !== 16'd0 || s_sat_count !== 4'd0) begin
      n_fail++; $display("FAIL ceil_clear: got %0d/%0d want 0", sat_count, s_sat_count);
    end
    out_ready = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1 in_valid = 1'b1;
      in_y = ($urandom_range(0, 1) == 1) ? 32'd100000001 + $urandom_range(0, 1000000)
                                         : 32'd0 - (32'd100000001 + $urandom_range(0, 1000000));
    end
    @(posedge clk); #1 in_valid = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    n_tests++;
    if (s_sat_count !== 4'd15) begin n_fail++; $display("FAIL ceil_small: got %0d want 15", s_sat_count); end
    n_tests++;
    if (sat_count !== 16'd20) begin n_fail++; $display("FAIL ceil_wide: got %0d want 20", sat_count); end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_directed();
    test_saturation();
    test_backpressure();
    test_random();
    test_reset_midstream();
    test_counter_ceiling();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
